// File: rtl/prefetch_queue_if.sv
// Handshake bundle between the prefetch queue and its neighbours: the IF stage
// (redirect, dequeue, instruction out), the MMU and the icache.
interface prefetch_queue_if #(
    parameter int XLEN = 32
);
    logic            clear_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            deq_i;
    logic            instr_valid_o;
    logic [31:0]     instr_o;
    logic            is_comp_o;
    logic [XLEN-1:0] pc_o;
    logic            fault_o;
    logic            mmu_req_o;
    logic [XLEN-1:0] mmu_vaddr_o;
    logic            mmu_hit_i;
    logic [XLEN-1:0] mmu_paddr_i;
    logic            mmu_page_fault_i;
    logic            icache_req_o;
    logic [XLEN-1:0] icache_addr_o;
    logic            icache_kill_o;
    logic            icache_ack_i;
    logic [31:0]     icache_rdata_i;

    modport master (
        input  clear_i, redirect_pc_i, deq_i,
        input  mmu_hit_i, mmu_paddr_i, mmu_page_fault_i,
        input  icache_ack_i, icache_rdata_i,
        output instr_valid_o, instr_o, is_comp_o, pc_o, fault_o,
        output mmu_req_o, mmu_vaddr_o,
        output icache_req_o, icache_addr_o, icache_kill_o
    );

    modport slave (
        output clear_i, redirect_pc_i, deq_i,
        output mmu_hit_i, mmu_paddr_i, mmu_page_fault_i,
        output icache_ack_i, icache_rdata_i,
        input  instr_valid_o, instr_o, is_comp_o, pc_o, fault_o,
        input  mmu_req_o, mmu_vaddr_o,
        input  icache_req_o, icache_addr_o, icache_kill_o
    );
endinterface

// File: rtl/prefetch_queue.sv
// Sequential instruction prefetcher: a 16-bit parcel queue fed word-by-word
// through MMU translation and the icache, presenting whole RV32/RV32C instructions.
//
// state | meaning
// IDLE  | no request outstanding; start one when two parcel slots are free
// TRANS | translation request for fetch_pc outstanding at the MMU
// FETCH | icache read of the translated word outstanding
module prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input logic              clk,
    input logic              rst_n,
    prefetch_queue_if.master bus
);
    localparam int NPAR = 2 * DEPTH;
    localparam int PW   = $clog2(NPAR);
    localparam int CW   = PW + 1;
    localparam logic [CW-1:0]   NPAR_C      = CW'(NPAR);
    localparam logic [XLEN-1:0] WORD_MASK   = ~XLEN'(3);
    localparam logic [XLEN-1:0] PARCEL_MASK = ~XLEN'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRANS = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t          state;
    logic [15:0]     parcels [NPAR];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] paddr_q;
    logic [XLEN-1:0] fault_pc;
    logic            drop_low;
    logic            fault_lat;
    logic            mmu_req_q;
    logic            icache_req_q;

    logic [PW-1:0]   head_p1;
    logic [PW-1:0]   tail_p1;
    logic [15:0]     p0;
    logic [15:0]     p1;
    logic            head_comp;
    logic            has_one;
    logic            has_two;
    logic            fault_now;
    logic            valid;
    logic            pop;
    logic            push;
    logic [PW-1:0]   pop_n;
    logic [PW-1:0]   push_n;
    logic [CW-1:0]   pop_amt;
    logic [CW-1:0]   push_amt;
    logic [CW-1:0]   free_slots;
    logic [CW-1:0]   rsv;
    logic            start_fetch;
    logic [XLEN-1:0] fault_probe;
    logic [XLEN-1:0] pc_step;

    always_comb begin
        head_p1   = head + PW'(1);
        tail_p1   = tail + PW'(1);
        p0        = parcels[head];
        p1        = parcels[head_p1];
        head_comp = (p0[1:0] != 2'b11);
        has_one   = (count != '0);
        has_two   = (count >= CW'(2));

        // A lone 32-bit head parcel belongs to the word before the faulting one.
        fault_probe = has_one ? (pc_q + XLEN'(2)) : pc_q;
        fault_now   = fault_lat
                      && (!has_one || (count == CW'(1) && !head_comp))
                      && ((fault_probe & WORD_MASK) == fault_pc);
        valid       = !fault_now && ((has_one && head_comp) || has_two);

        pop      = bus.deq_i && valid;
        pop_n    = head_comp ? PW'(1) : PW'(2);
        pop_amt  = pop ? CW'(pop_n) : '0;
        pc_step  = head_comp ? XLEN'(2) : XLEN'(4);

        push     = (state == FETCH) && bus.icache_ack_i;
        push_n   = drop_low ? PW'(1) : PW'(2);
        push_amt = push ? CW'(push_n) : '0;

        // Two slots stay reserved for the word in flight from TRANS until its ack.
        free_slots  = NPAR_C - count;
        rsv         = (state != IDLE) ? CW'(2) : '0;
        start_fetch = (state == IDLE) && !fault_lat && (free_slots >= rsv + CW'(2));
    end

    assign bus.instr_valid_o = valid;
    assign bus.instr_o       = !has_one ? 32'h0 : (head_comp ? {16'h0, p0} : {p1, p0});
    assign bus.is_comp_o     = has_one && head_comp;
    assign bus.pc_o          = pc_q;
    assign bus.fault_o       = fault_now;
    assign bus.mmu_req_o     = mmu_req_q;
    assign bus.mmu_vaddr_o   = fetch_pc;
    assign bus.icache_req_o  = icache_req_q;
    assign bus.icache_addr_o = paddr_q;
    assign bus.icache_kill_o = bus.clear_i && (state == FETCH);

    always_ff @(posedge clk) begin
        if (rst_n && !bus.clear_i && push) begin
            if (drop_low) begin
                parcels[tail] <= bus.icache_rdata_i[31:16];
            end else begin
                parcels[tail]    <= bus.icache_rdata_i[15:0];
                parcels[tail_p1] <= bus.icache_rdata_i[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pc_q         <= '0;
            fetch_pc     <= '0;
            paddr_q      <= '0;
            fault_pc     <= '0;
            drop_low     <= 1'b0;
            fault_lat    <= 1'b0;
            mmu_req_q    <= 1'b0;
            icache_req_q <= 1'b0;
        end else if (bus.clear_i) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pc_q         <= bus.redirect_pc_i & PARCEL_MASK;
            fetch_pc     <= bus.redirect_pc_i & WORD_MASK;
            drop_low     <= bus.redirect_pc_i[1];
            fault_lat    <= 1'b0;
            mmu_req_q    <= 1'b0;
            icache_req_q <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + push_n;
            end
            if (pop) begin
                head <= head + pop_n;
                pc_q <= pc_q + pc_step;
            end
            count <= count + push_amt - pop_amt;

            case (state)
                IDLE: begin
                    if (start_fetch) begin
                        state     <= TRANS;
                        mmu_req_q <= 1'b1;
                    end
                end
                TRANS: begin
                    if (bus.mmu_hit_i) begin
                        mmu_req_q <= 1'b0;
                        if (bus.mmu_page_fault_i) begin
                            fault_lat <= 1'b1;
                            fault_pc  <= fetch_pc;
                            state     <= IDLE;
                        end else begin
                            paddr_q      <= bus.mmu_paddr_i & WORD_MASK;
                            icache_req_q <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (bus.icache_ack_i) begin
                        icache_req_q <= 1'b0;
                        drop_low     <= 1'b0;
                        fetch_pc     <= fetch_pc + XLEN'(4);
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    mmu_req_q    <= 1'b0;
                    icache_req_q <= 1'b0;
                end
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= NPAR_C);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || bus.clear_i)
                                    push |-> (count - pop_amt + push_amt) <= NPAR_C);
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: instruction-stream vector table plus
// hand-written sequences for backpressure, page fault and redirect-during-fetch.
module tb_prefetch_queue;
    localparam int XLEN = 32;
    localparam logic [31:0] PA_OFS = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prefetch_queue_if #(.XLEN(XLEN)) bus ();

    prefetch_queue #(.DEPTH(4), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [256];
    logic        ack_en = 1'b1;
    logic        fault_en = 1'b0;
    logic [31:0] fault_addr = 32'h0;
    logic [31:0] resp_addr;
    int          ack_cnt = 0;
    int          mmu_cnt = 0;

    typedef struct {
        logic        restart;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic pulse_clear(input logic [31:0] rpc);
        bus.clear_i       = 1'b1;
        bus.redirect_pc_i = rpc;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    task automatic deq_one();
        bus.deq_i = 1'b1;
        @(negedge clk);
        bus.deq_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.instr_valid_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"}, 32'(bus.instr_valid_o), 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.icache_req_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.icache_req_o), 32'd1);
    endtask

    // MMU/icache model: one-cycle responses, paddr = vaddr + PA_OFS.
    initial begin
        bus.mmu_hit_i        = 1'b0;
        bus.mmu_paddr_i      = '0;
        bus.mmu_page_fault_i = 1'b0;
        bus.icache_ack_i     = 1'b0;
        bus.icache_rdata_i   = '0;
        forever begin
            @(negedge clk);
            resp_addr            = bus.icache_addr_o - PA_OFS;
            bus.mmu_hit_i        = bus.mmu_req_o;
            bus.mmu_paddr_i      = bus.mmu_vaddr_o + PA_OFS;
            bus.mmu_page_fault_i = bus.mmu_req_o && fault_en && (bus.mmu_vaddr_o == fault_addr);
            bus.icache_ack_i     = bus.icache_req_o && ack_en;
            bus.icache_rdata_i   = mem[resp_addr[9:2]];
            if (bus.icache_ack_i) ack_cnt++;
            if (bus.mmu_hit_i) mmu_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;

        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0020_0093, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         32'h0000_0004, 32'h0040_0113, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0001, 1'b1};
        vecs[3] = '{1'b0, 32'h0,         32'h0000_0042, 32'h0093_0093, 1'b0};
        vecs[4] = '{1'b0, 32'h0,         32'h0000_0046, 32'h0000_1113, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0086, 32'h0000_0086, 32'h0000_81B3, 1'b0};
        vecs[6] = '{1'b0, 32'h0,         32'h0000_008A, 32'h0000_0000, 1'b1};
        vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0050_0193, 1'b0};
        vecs[8] = '{1'b0, 32'h0,         32'h0000_0000, 32'h0020_0093, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h0020_0093;
        mem[1]   = 32'h0040_0113;
        mem[16]  = 32'h0093_0001;
        mem[17]  = 32'h1113_0093;
        mem[33]  = 32'h81B3_4505;
        mem[255] = 32'h0050_0193;
        for (int i = 48; i < 64; i++) mem[i] = {12'(i), 20'h00013};

        bus.clear_i       = 1'b0;
        bus.redirect_pc_i = '0;
        bus.deq_i         = 1'b0;

        // reset
        repeat (3) @(negedge clk);
        check("rst instr_valid", 32'(bus.instr_valid_o), 32'd0);
        check("rst instr", bus.instr_o, 32'd0);
        check("rst is_comp", 32'(bus.is_comp_o), 32'd0);
        check("rst pc", bus.pc_o, 32'd0);
        check("rst fault", 32'(bus.fault_o), 32'd0);
        check("rst mmu_req", 32'(bus.mmu_req_o), 32'd0);
        check("rst mmu_vaddr", bus.mmu_vaddr_o, 32'd0);
        check("rst icache_req", 32'(bus.icache_req_o), 32'd0);
        check("rst icache_kill", 32'(bus.icache_kill_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // instruction stream table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].restart) pulse_clear(vecs[i].rpc);
            wait_valid($sformatf("vec%0d", i));
            check($sformatf("vec%0d pc", i), bus.pc_o, vecs[i].pc);
            check($sformatf("vec%0d instr", i), bus.instr_o, vecs[i].instr);
            check($sformatf("vec%0d is_comp", i), 32'(bus.is_comp_o), 32'(vecs[i].comp));
            deq_one();
        end

        // backpressure: no dequeue fills 8 parcels = 4 words, then stalls
        pulse_clear(32'h0000_00C0);
        base = ack_cnt;
        repeat (60) @(negedge clk);
        check("full req count", 32'(ack_cnt - base), 32'd4);
        check("full icache_req", 32'(bus.icache_req_o), 32'd0);
        check("full mmu_req", 32'(bus.mmu_req_o), 32'd0);
        check("full pc", bus.pc_o, 32'h0000_00C0);
        check("full instr", bus.instr_o, mem[48]);
        deq_one();
        wait_req("refill req");
        check("pop+push valid", 32'(bus.instr_valid_o), 32'd1);
        check("pop+push pc", bus.pc_o, 32'h0000_00C4);
        deq_one();
        repeat (40) @(negedge clk);
        check("refill req count", 32'(ack_cnt - base), 32'd6);
        check("refill icache_req", 32'(bus.icache_req_o), 32'd0);
        for (int k = 0; k < 6; k++) begin
            wait_valid($sformatf("drain%0d", k));
            check($sformatf("drain%0d pc", k), bus.pc_o, 32'h0000_00C8 + 32'(4 * k));
            check($sformatf("drain%0d instr", k), bus.instr_o, mem[50 + k]);
            deq_one();
        end

        // page fault on the third word
        fault_addr = 32'h0000_0008;
        fault_en   = 1'b1;
        pulse_clear(32'h0000_0000);
        wait_valid("flt i0");
        check("flt i0 fault", 32'(bus.fault_o), 32'd0);
        check("flt i0 pc", bus.pc_o, 32'h0000_0000);
        check("flt i0 instr", bus.instr_o, 32'h0020_0093);
        deq_one();
        wait_valid("flt i1");
        check("flt i1 pc", bus.pc_o, 32'h0000_0004);
        check("flt i1 instr", bus.instr_o, 32'h0040_0113);
        deq_one();
        n = 0;
        while (!bus.fault_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("flt fault_o", 32'(bus.fault_o), 32'd1);
        check("flt pc", bus.pc_o, 32'h0000_0008);
        check("flt instr_valid", 32'(bus.instr_valid_o), 32'd0);
        base = mmu_cnt;
        repeat (20) @(negedge clk);
        check("flt no mmu_req", 32'(mmu_cnt - base), 32'd0);
        check("flt fault held", 32'(bus.fault_o), 32'd1);
        fault_en = 1'b0;
        pulse_clear(32'h0000_0100);
        check("flt cleared", 32'(bus.fault_o), 32'd0);
        check("flt redirect vaddr", bus.mmu_vaddr_o, 32'h0000_0100);
        n = 0;
        while (!bus.mmu_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("flt restart mmu_req", 32'(bus.mmu_req_o), 32'd1);
        check("flt restart vaddr", bus.mmu_vaddr_o, 32'h0000_0100);

        // clear while FETCH with the ack landing in the same cycle
        pulse_clear(32'h0000_0000);
        wait_req("kill1 req");
        check("kill1 icache_addr", bus.icache_addr_o, PA_OFS);
        bus.clear_i       = 1'b1;
        bus.redirect_pc_i = 32'h0000_0040;
        #1;
        check("kill1 icache_kill", 32'(bus.icache_kill_o), 32'd1);
        @(negedge clk);
        bus.clear_i = 1'b0;
        check("kill1 empty valid", 32'(bus.instr_valid_o), 32'd0);
        check("kill1 empty instr", bus.instr_o, 32'd0);
        check("kill1 pc", bus.pc_o, 32'h0000_0040);
        check("kill1 vaddr", bus.mmu_vaddr_o, 32'h0000_0040);
        check("kill1 kill drop", 32'(bus.icache_kill_o), 32'd0);
        wait_valid("kill1 restart");
        check("kill1 restart pc", bus.pc_o, 32'h0000_0040);
        check("kill1 restart instr", bus.instr_o, 32'h0000_0001);

        // clear while FETCH with no ack
        ack_en = 1'b0;
        pulse_clear(32'h0000_0000);
        wait_req("kill2 req");
        bus.clear_i       = 1'b1;
        bus.redirect_pc_i = 32'h0000_0086;
        #1;
        check("kill2 icache_kill", 32'(bus.icache_kill_o), 32'd1);
        ack_en = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        wait_valid("kill2 restart");
        check("kill2 restart pc", bus.pc_o, 32'h0000_0086);
        check("kill2 restart instr", bus.instr_o, 32'h0000_81B3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
